// File: rtl/serial_equality_checker.sv
// Bit-serial equality checker: consumes WIDTH (a, b) pairs per word and reports
// whether every pair matched plus the number of mismatching pairs.
module serial_equality_checker #(
    parameter int WIDTH = 8,
    localparam int CW = $clog2(WIDTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          bit_valid,
    input  logic          a,
    input  logic          b,
    output logic          busy,
    output logic          done,
    output logic          eq,
    output logic [CW-1:0] mismatches,
    output logic [1:0]    state_dbg
);

    // Handshake: bit_valid qualifies a/b in SHIFT only; there is no backpressure,
    // every SHIFT-state edge with bit_valid=1 consumes exactly one pair.
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

    logic [1:0]    state;
    logic [1:0]    state_nxt;
    logic [CW-1:0] bit_cnt;
    logic [CW-1:0] run_cnt;
    logic [CW-1:0] run_cnt_nxt;
    logic          match;
    logic          consume;
    logic          last_pair;
    logic          accept_start;

    assign match        = ~(a ^ b);
    assign consume      = (state == SHIFT) && bit_valid;
    assign last_pair    = (bit_cnt == LAST_IDX);
    assign accept_start = ((state == IDLE) || (state == DONE)) && start;
    assign run_cnt_nxt  = run_cnt + CW'(~match);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SHIFT;
            SHIFT:   if (consume && last_pair) state_nxt = DONE;
            DONE:    state_nxt = start ? SHIFT : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            run_cnt    <= '0;
            eq         <= 1'b0;
            mismatches <= '0;
        end else begin
            state <= state_nxt;
            if (accept_start) begin
                bit_cnt <= '0;
                run_cnt <= '0;
            end else if (consume) begin
                bit_cnt <= bit_cnt + CW'(1);
                run_cnt <= run_cnt_nxt;
                // Result registers change only when a full word completes.
                if (last_pair) begin
                    mismatches <= run_cnt_nxt;
                    eq         <= (run_cnt_nxt == '0);
                end
            end
        end
    end

    assign busy      = (state == SHIFT);
    assign done      = (state == DONE);
    assign state_dbg = state;

endmodule

// File: tb/tb_serial_equality_checker.sv
// Bench for serial_equality_checker (WIDTH=8): table-driven words plus hand
// sequences for mid-word start, mid-word reset and back-to-back words.
module tb_serial_equality_checker;

    localparam int W  = 8;
    localparam int CW = $clog2(W + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          bit_valid;
    logic          a;
    logic          b;
    logic          busy;
    logic          done;
    logic          eq;
    logic [CW-1:0] mismatches;
    logic [1:0]    state_dbg;

    serial_equality_checker #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .bit_valid  (bit_valid),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .eq         (eq),
        .mismatches (mismatches),
        .state_dbg  (state_dbg)
    );

    // clock / cycle counter
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // scoreboard
    logic [CW:0] exp_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    logic        last_eq;
    logic [CW-1:0] last_mism;
    int          done_cyc;

    typedef struct {
        logic [W-1:0]  a_w;
        logic [W-1:0]  b_w;
        int            stall_at;
        int            stall_len;
        bit            start_with_valid;
        logic          exp_eq;
        logic [CW-1:0] exp_mism;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drives WIDTH pairs MSB first; assumes the DUT is already in SHIFT.
    task automatic send_bits(input logic [W-1:0] a_w, input logic [W-1:0] b_w,
                             input int stall_at, input int stall_len, input int start_at);
        for (int i = W - 1; i >= 0; i--) begin
            int idx;
            idx = W - 1 - i;
            if (idx == stall_at) begin
                for (int s = 0; s < stall_len; s++) begin
                    bit_valid = 1'b0;
                    a = 1'($urandom_range(0, 1));
                    b = ~a;
                    @(posedge clk); #1;
                end
            end
            if (idx == 4) begin
                check("mid_busy", busy, 1'b1);
                check("mid_state", state_dbg, ST_SHIFT);
                check("hold_eq", eq, last_eq);
                check("hold_mism", mismatches, last_mism);
            end
            a = a_w[i];
            b = b_w[i];
            bit_valid = 1'b1;
            if (idx == start_at) start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
        end
        bit_valid = 1'b0;
    endtask

    // Waits (bounded) for done, checks its cycle and pops the scoreboard.
    task automatic wait_done(input int exp_cyc);
        logic [CW:0] exp;
        bit found;
        found = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done) begin
                found = 1'b1;
                break;
            end
        end
        exp = exp_q.pop_front();
        if (!found) begin
            n_cmp++;
            n_err++;
            $display("FAIL done_timeout: no done within 20 cycles, expected at cycle %0d", exp_cyc);
        end else begin
            done_cyc = cyc;
            check("done_latency", cyc, exp_cyc);
            check("result_eq", eq, exp[CW]);
            check("result_mism", mismatches, exp[CW-1:0]);
            check("busy_in_done", busy, 1'b0);
        end
        last_eq   = exp[CW];
        last_mism = exp[CW-1:0];
    endtask

    task automatic run_word(input logic [W-1:0] a_w, input logic [W-1:0] b_w,
                            input int stall_at, input int stall_len,
                            input bit start_with_valid, input int start_at,
                            input logic exp_eq, input logic [CW-1:0] exp_mism,
                            input bit b2b);
        int cyc_start;
        @(posedge clk); #1;
        start = 1'b1;
        bit_valid = start_with_valid;
        a = 1'b1;
        b = 1'b0;
        exp_q.push_back({exp_eq, exp_mism});
        @(posedge clk); #1;
        start = 1'b0;
        bit_valid = 1'b0;
        cyc_start = cyc;
        check("busy_after_start", busy, 1'b1);
        send_bits(a_w, b_w, stall_at, stall_len, start_at);
        wait_done(cyc_start + W + stall_len);
        if (!b2b) begin
            @(negedge clk);
            check("done_single_pulse", done, 1'b0);
            check("idle_after_done", state_dbg, ST_IDLE);
        end
    endtask

    initial begin
        int first_done;
        int cyc_start;
        vecs[0] = '{8'b10110010, 8'b10110010, -1, 0, 1'b0, 1'b1, 4'd0};
        vecs[1] = '{8'b11111111, 8'b00000000, -1, 0, 1'b0, 1'b0, 4'd8};
        vecs[2] = '{8'b10101010, 8'b10101011, -1, 0, 1'b0, 1'b0, 4'd1};
        vecs[3] = '{8'b10110010, 8'b10110010,  4, 3, 1'b0, 1'b1, 4'd0};
        vecs[4] = '{8'b00111100, 8'b00111100, -1, 0, 1'b1, 1'b1, 4'd0};
        for (int v = 5; v < 8; v++) begin
            vecs[v].a_w = W'($urandom);
            vecs[v].b_w = W'($urandom);
            vecs[v].stall_at = int'($urandom_range(0, W - 1));
            vecs[v].stall_len = int'($urandom_range(0, 2));
            vecs[v].start_with_valid = 1'($urandom_range(0, 1));
            vecs[v].exp_mism = CW'($countones(vecs[v].a_w ^ vecs[v].b_w));
            vecs[v].exp_eq = (vecs[v].a_w == vecs[v].b_w);
        end

        rst_n = 1'b0;
        start = 1'b0;
        bit_valid = 1'b0;
        a = 1'b0;
        b = 1'b0;
        last_eq = 1'b0;
        last_mism = '0;
        done_cyc = 0;
        #3;
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        check("reset_eq", eq, 1'b0);
        check("reset_mism", mismatches, '0);
        check("reset_state", state_dbg, ST_IDLE);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int v = 0; v < 8; v++) begin
            run_word(vecs[v].a_w, vecs[v].b_w, vecs[v].stall_at, vecs[v].stall_len,
                     vecs[v].start_with_valid, -1, vecs[v].exp_eq, vecs[v].exp_mism, 1'b0);
        end

        // start pulsed mid-word must be ignored: latency and result unchanged
        run_word(8'h5a, 8'h5b, -1, 0, 1'b0, 2, 1'b0, 4'd1, 1'b0);

        // reset after 4 bits of a word, asserted mid-cycle
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            a = 1'b1;
            b = 1'b0;
            bit_valid = 1'b1;
            @(posedge clk); #1;
        end
        check("pre_reset_busy", busy, 1'b1);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_busy", busy, 1'b0);
        check("async_rst_done", done, 1'b0);
        check("async_rst_eq", eq, 1'b0);
        check("async_rst_mism", mismatches, '0);
        check("async_rst_state", state_dbg, ST_IDLE);
        bit_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        last_eq = 1'b0;
        last_mism = '0;
        repeat (2) @(posedge clk);
        #1;
        check("post_reset_idle", state_dbg, ST_IDLE);
        run_word(8'hc3, 8'hc3, -1, 0, 1'b0, -1, 1'b1, 4'd0, 1'b0);

        // back-to-back: start asserted in the DONE cycle of the first word
        run_word(8'hf0, 8'h0f, -1, 0, 1'b0, -1, 1'b0, 4'd8, 1'b1);
        first_done = done_cyc;
        start = 1'b1;
        exp_q.push_back({1'b1, 4'd0});
        @(posedge clk); #1;
        start = 1'b0;
        cyc_start = cyc;
        check("b2b_busy", busy, 1'b1);
        send_bits(8'h81, 8'h81, -1, 0, -1);
        wait_done(cyc_start + W);
        check("b2b_spacing", done_cyc - first_done, 9);

        repeat (3) @(posedge clk);
        check("queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/serial_equality_checker.md
SERIAL_EQUALITY_CHECKER -- requirements
Module: serial_equality_checker

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning the number of bit pairs per comparison word; legal range 1..32.
REQ-002 SHALL have derived width CW = $clog2(WIDTH+1), meaning the width of the mismatch counter.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset; one clock; reset is asynchronous and active-low.
REQ-005 SHALL have port start, input, 1, requests a new comparison word.
REQ-006 SHALL have port bit_valid, input, 1, qualifies a and b as a bit pair in the current cycle.
REQ-007 SHALL have port a, input, 1, serial bit from stream A.
REQ-008 SHALL have port b, input, 1, serial bit from stream B.
REQ-009 SHALL have port busy, output, 1, high while a word is being consumed.
REQ-010 SHALL have port done, output, 1, one-cycle pulse marking a valid result.
REQ-011 SHALL have port eq, output, 1, high when all WIDTH bit pairs of the last word matched.
REQ-012 SHALL have port mismatches, output, CW, count of non-matching bit pairs in the last word.

Function
REQ-013 SHALL implement an FSM with the states IDLE, SHIFT and DONE.
REQ-014 IDLE: on start=1 SHALL go to SHIFT and clear the bit counter and running mismatch count; otherwise SHALL stay in IDLE.
REQ-015 SHIFT: on each edge with bit_valid=1 SHALL consume one pair, compute match = ~(a ^ b), increment the running count when match=0, and increment the bit counter.
REQ-016 SHIFT: bit_valid=0 SHALL stall; counters hold and nothing is consumed.
REQ-017 SHIFT: on the edge that consumes pair number WIDTH, SHALL load mismatches with the final count, load eq with (final count == 0), and go to DONE.
REQ-018 DONE SHALL last exactly one cycle with done=1, then go to IDLE, or go to SHIFT if start=1 in that cycle (back-to-back word).
REQ-019 busy SHALL be 1 only in SHIFT; done SHALL be 1 only in DONE.
REQ-020 start SHALL be ignored while in SHIFT; bit_valid, a and b SHALL be ignored in IDLE and DONE.
REQ-021 eq and mismatches SHALL hold their values until the next word completes; a partial word SHALL never alter them.
REQ-022 Latency: with bit_valid held at 1, done SHALL be high in the cycle after edge WIDTH+1, counting the edge that samples start as edge 1.
REQ-023 The running count SHALL NOT overflow: its maximum is WIDTH, which fits CW.
REQ-024 Simultaneous start and bit_valid in IDLE: SHALL accept start only; the pair in that cycle SHALL NOT be consumed.

Reset
REQ-025 rst_n=0 SHALL immediately, without waiting for a clock edge, force IDLE, clear both counters, and set busy=0, done=0, eq=0, mismatches=0.
REQ-026 Reset during SHIFT SHALL discard the partial word; the first start after rst_n returns to 1 SHALL begin a fresh word.

Verification (WIDTH=8)
REQ-027 Reset: drive rst_n=0 mid-cycle -> all outputs 0 before the next clk edge.
REQ-028 a = b = 10110010, bit_valid held 1 -> eq=1, mismatches=0, single done pulse in the cycle after edge 9.
REQ-029 a=11111111, b=00000000 -> eq=0, mismatches=8; a=10101010, b=10101011 -> eq=0, mismatches=1.
REQ-030 Matching word with bit_valid=0 for 3 cycles after bit 4 -> same result as REQ-028, done delayed by exactly 3 cycles.
REQ-031 rst_n pulsed low after 4 bits -> outputs 0 and state IDLE; a new start with a = b -> eq=1, mismatches=0.
REQ-032 start asserted during SHIFT -> no effect; start asserted in the DONE cycle -> second word starts immediately and its done arrives 9 cycles after the first.
